// File: rtl/sar_word_fifo.sv
// Rebuilds 8-bit SAR results from the serial bit stream (one bit per COMP_CLK fall) into a 4-deep
// fall-through FIFO; word visible the cycle after its push; a push into a full FIFO without a pop is dropped and sets OVERFLOW.
module sar_word_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              COMP_CLK,
    input  logic              DIGITAL_OUT,
    input  logic              EN,
    input  logic              CLR_OVF,
    output logic [DATA_W-1:0] DOUT_DATA,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic [AW:0]       FIFO_LEVEL,
    output logic              OVERFLOW,
    output logic [15:0]       WORD_CNT
);
    localparam int CW = $clog2(DATA_W);

    logic [DATA_W-2:0] sreg;
    logic [CW-1:0]     bit_cnt;
    logic              comp_clk_d;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              fall;
    logic              push;
    logic              pop;
    logic              full;
    logic              wr_en;
    logic              drop;
    logic [DATA_W-1:0] word;

    assign fall       = comp_clk_d & ~COMP_CLK;
    assign word       = {sreg, DIGITAL_OUT};
    assign push       = fall & EN & (bit_cnt == CW'(DATA_W - 1));
    assign full       = (FIFO_LEVEL == (AW+1)'(DEPTH));
    assign DOUT_VALID = (FIFO_LEVEL != '0);
    assign DOUT_DATA  = mem[rd_ptr];
    assign pop        = DOUT_VALID & DOUT_READY;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en      = push & (~full | pop);
    assign drop       = push & full & ~pop;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sreg       <= '0;
            bit_cnt    <= '0;
            comp_clk_d <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
            OVERFLOW   <= 1'b0;
            WORD_CNT   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            comp_clk_d <= COMP_CLK;

            // Disabling capture discards any partial word so the next enable starts at the MSB.
            if (!EN) begin
                sreg    <= '0;
                bit_cnt <= '0;
            end else if (fall) begin
                sreg    <= word[DATA_W-2:0];
                bit_cnt <= push ? '0 : bit_cnt + 1'b1;
            end

            if (wr_en) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + 1'b1;
                WORD_CNT    <= WORD_CNT + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({wr_en, pop})
                2'b10:   FIFO_LEVEL <= FIFO_LEVEL + 1'b1;
                2'b01:   FIFO_LEVEL <= FIFO_LEVEL - 1'b1;
                default: FIFO_LEVEL <= FIFO_LEVEL;
            endcase

            if (drop) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_OVF) begin
                OVERFLOW <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sar_word_fifo.sv
// Bench for sar_word_fifo: directed table vectors, hand sequences, and randomized ops vs a queue model.
module tb_sar_word_fifo;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        COMP_CLK = 1'b0;
    logic        DIGITAL_OUT = 1'b0;
    logic        EN = 1'b0;
    logic        CLR_OVF = 1'b0;
    logic [7:0]  DOUT_DATA;
    logic        DOUT_VALID;
    logic        DOUT_READY = 1'b0;
    logic [2:0]  FIFO_LEVEL;
    logic        OVERFLOW;
    logic [15:0] WORD_CNT;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: words in the queue, sticky flag, accepted-word count.
    logic [7:0]  model_q[$];
    logic        model_ovf;
    logic [15:0] model_cnt;

    typedef struct {
        logic [7:0]  din;
        logic [2:0]  exp_level;
        logic        exp_ovf;
        logic [15:0] exp_cnt;
    } vec_t;
    vec_t vecs[5];

    sar_word_fifo #(.DATA_W(8), .DEPTH(4), .AW(2)) dut (
        .CLK(CLK), .RST(RST), .COMP_CLK(COMP_CLK), .DIGITAL_OUT(DIGITAL_OUT),
        .EN(EN), .CLR_OVF(CLR_OVF), .DOUT_DATA(DOUT_DATA), .DOUT_VALID(DOUT_VALID),
        .DOUT_READY(DOUT_READY), .FIFO_LEVEL(FIFO_LEVEL), .OVERFLOW(OVERFLOW),
        .WORD_CNT(WORD_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        model_cnt = '0;
    endtask

    // One SAR bit period of 6 CLK; the fall is seen on the 3rd posedge. rdy/clr are held for the fall cycle only.
    task automatic send_bit(input logic b, input logic rdy, input logic clr);
        @(negedge CLK);
        COMP_CLK    = 1'b1;
        DIGITAL_OUT = b;
        repeat (2) @(negedge CLK);
        COMP_CLK    = 1'b0;
        DOUT_READY  = rdy;
        CLR_OVF     = clr;
        @(negedge CLK);
        DOUT_READY  = 1'b0;
        CLR_OVF     = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic send_word(input logic [7:0] w, input logic rdy_last, input logic clr_last);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i], (i == 0) & rdy_last, (i == 0) & clr_last);
        end
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        @(negedge CLK);
        chk({name, "_valid"}, 32'(DOUT_VALID), 32'd1);
        chk({name, "_data"}, 32'(DOUT_DATA), 32'(exp));
        DOUT_READY = 1'b1;
        @(negedge CLK);
        DOUT_READY = 1'b0;
    endtask

    task automatic model_push(input logic [7:0] w);
        if (model_q.size() < 4) begin
            model_q.push_back(w);
            model_cnt++;
        end else begin
            model_ovf = 1'b1;
        end
    endtask

    task automatic check_model(input string name);
        chk({name, "_level"}, 32'(FIFO_LEVEL), 32'(model_q.size()));
        chk({name, "_valid"}, 32'(DOUT_VALID), 32'(model_q.size() != 0));
        chk({name, "_ovf"}, 32'(OVERFLOW), 32'(model_ovf));
        chk({name, "_cnt"}, 32'(WORD_CNT), 32'(model_cnt));
        if (model_q.size() != 0) chk({name, "_head"}, 32'(DOUT_DATA), 32'(model_q[0]));
    endtask

    initial begin
        vecs[0] = '{8'h01, 3'd1, 1'b0, 16'd1};
        vecs[1] = '{8'h02, 3'd2, 1'b0, 16'd2};
        vecs[2] = '{8'h03, 3'd3, 1'b0, 16'd3};
        vecs[3] = '{8'h04, 3'd4, 1'b0, 16'd4};
        vecs[4] = '{8'h05, 3'd4, 1'b1, 16'd4};

        // Reset state
        do_reset();
        @(negedge CLK);
        chk("rst_valid", 32'(DOUT_VALID), 32'd0);
        chk("rst_data", 32'(DOUT_DATA), 32'd0);
        chk("rst_level", 32'(FIFO_LEVEL), 32'd0);
        chk("rst_ovf", 32'(OVERFLOW), 32'd0);
        chk("rst_cnt", 32'(WORD_CNT), 32'd0);

        // Basic assembly of 0xB2
        EN = 1'b1;
        begin
            logic [7:0] w;
            w = 8'hB2;
            for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0, 1'b0);
            chk("basic_pre_valid", 32'(DOUT_VALID), 32'd0);
            send_bit(w[0], 1'b0, 1'b0);
        end
        chk("basic_valid", 32'(DOUT_VALID), 32'd1);
        chk("basic_data", 32'(DOUT_DATA), 32'hB2);
        chk("basic_level", 32'(FIFO_LEVEL), 32'd1);
        chk("basic_cnt", 32'(WORD_CNT), 32'd1);

        // Fill and overflow, table driven
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_word(vecs[i].din, 1'b0, 1'b0);
            chk($sformatf("fill%0d_level", i), 32'(FIFO_LEVEL), 32'(vecs[i].exp_level));
            chk($sformatf("fill%0d_ovf", i), 32'(OVERFLOW), 32'(vecs[i].exp_ovf));
            chk($sformatf("fill%0d_cnt", i), 32'(WORD_CNT), 32'(vecs[i].exp_cnt));
        end

        // CLR_OVF coincident with a dropped push: set wins
        send_word(8'h06, 1'b0, 1'b1);
        chk("clrpri_ovf_hold", 32'(OVERFLOW), 32'd1);
        chk("clrpri_cnt", 32'(WORD_CNT), 32'd4);
        @(negedge CLK);
        CLR_OVF = 1'b1;
        @(negedge CLK);
        CLR_OVF = 1'b0;
        chk("clrpri_ovf_clear", 32'(OVERFLOW), 32'd0);

        for (int i = 1; i <= 4; i++) pop_expect($sformatf("fillpop%0d", i), 8'(i));
        @(negedge CLK);
        chk("fill_empty_valid", 32'(DOUT_VALID), 32'd0);
        chk("fill_empty_level", 32'(FIFO_LEVEL), 32'd0);

        // Full push+pop in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) send_word(8'h10 + 8'(i), 1'b0, 1'b0);
        send_word(8'h14, 1'b1, 1'b0);
        chk("fullpp_level", 32'(FIFO_LEVEL), 32'd4);
        chk("fullpp_ovf", 32'(OVERFLOW), 32'd0);
        chk("fullpp_cnt", 32'(WORD_CNT), 32'd5);
        for (int i = 1; i <= 4; i++) pop_expect($sformatf("fullpp_pop%0d", i), 8'h10 + 8'(i));

        // Enable gating discards a partial word
        do_reset();
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        EN = 1'b0;
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        EN = 1'b1;
        send_word(8'hA5, 1'b0, 1'b0);
        chk("engate_level", 32'(FIFO_LEVEL), 32'd1);
        chk("engate_data", 32'(DOUT_DATA), 32'hA5);
        chk("engate_cnt", 32'(WORD_CNT), 32'd1);

        // Asynchronous reset mid-operation
        do_reset();
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0, 1'b0);
        chk("midrst_pre_level", 32'(FIFO_LEVEL), 32'd2);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("midrst_valid", 32'(DOUT_VALID), 32'd0);
        chk("midrst_level", 32'(FIFO_LEVEL), 32'd0);
        chk("midrst_cnt", 32'(WORD_CNT), 32'd0);
        chk("midrst_ovf", 32'(OVERFLOW), 32'd0);
        #1 RST = 1'b0;
        send_word(8'hFF, 1'b0, 1'b0);
        chk("midrst_ff_data", 32'(DOUT_DATA), 32'hFF);
        chk("midrst_ff_level", 32'(FIFO_LEVEL), 32'd1);

        // Randomized operations against the queue model
        do_reset();
        EN = 1'b1;
        for (int it = 0; it < 60; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                logic [7:0] w;
                w = 8'($urandom);
                send_word(w, 1'b0, 1'b0);
                model_push(w);
            end else if (op <= 7) begin
                int n;
                n = $urandom_range(1, 2);
                for (int k = 0; k < n; k++) begin
                    if (model_q.size() != 0) begin
                        pop_expect($sformatf("rnd%0d_pop", it), model_q.pop_front());
                    end else begin
                        @(negedge CLK);
                        DOUT_READY = 1'b1;
                        @(negedge CLK);
                        DOUT_READY = 1'b0;
                    end
                end
                @(negedge CLK);
            end else if (op == 8) begin
                @(negedge CLK);
                CLR_OVF = 1'b1;
                @(negedge CLK);
                CLR_OVF = 1'b0;
                model_ovf = 1'b0;
            end else begin
                int nb;
                nb = $urandom_range(1, 7);
                for (int k = 0; k < nb; k++) send_bit(1'($urandom), 1'b0, 1'b0);
                @(negedge CLK);
                EN = 1'b0;
                @(negedge CLK);
                EN = 1'b1;
            end
            check_model($sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sar_word_fifo.md
Name: sar_word_fifo

Overview:
- Downstream consumer of the SAR logic. It rebuilds each 8-bit conversion result from the per-bit serial DIGITAL_OUT stream, using COMP_CLK falling edges as the bit strobe.
- Completed words are buffered in a small FIFO and presented on a valid/ready port to the host-side readout logic.
- Word count and sticky overflow status are provided for debug.

Parameters:
- DATA_W, 8, bits per conversion; must equal ADC resolution.
- DEPTH, 4, FIFO depth in words; power of two, at least 2.
- AW, 2, log2(DEPTH).

Ports:
- CLK  input  1  system clock, same 48 MHz clock as SAR logic.
- RST  input  1  asynchronous active-high reset.
- COMP_CLK  input  1  comparator clock from SAR logic, registered in the CLK domain.
- DIGITAL_OUT  input  1  per-bit decision from SAR logic, MSB first.
- EN  input  1  capture enable.
- CLR_OVF  input  1  synchronous clear of OVERFLOW.
- DOUT_DATA  output  DATA_W  word at FIFO head.
- DOUT_VALID  output  1  FIFO not empty.
- DOUT_READY  input  1  consumer accepts head word.
- FIFO_LEVEL  output  AW+1  words stored, 0..DEPTH.
- OVERFLOW  output  1  sticky: a completed word was dropped.
- WORD_CNT  output  16  words accepted into FIFO; wraps 0xFFFF->0.

Behaviour:
- Reset values (RST=1, async): shift register 0, bit_cnt 0, comp_clk_d 0, pointers 0, FIFO_LEVEL 0, DOUT_VALID 0, DOUT_DATA 0, OVERFLOW 0, WORD_CNT 0. Memory contents are don't-care.
- Bit strobe: fall = comp_clk_d & ~COMP_CLK, where comp_clk_d is COMP_CLK delayed one CLK.
  - DIGITAL_OUT is stable from SAR state 6 through the following state 5, so it is sampled directly in the fall cycle.
  - No extra synchronizer; both signals are in the CLK domain.
- Capture, on fall with EN=1:
  - sreg <= {sreg[DATA_W-2:0], DIGITAL_OUT}; bit_cnt <= bit_cnt+1.
  - When bit_cnt==DATA_W-1: word = {sreg[DATA_W-2:0], DIGITAL_OUT}, push is asserted, bit_cnt <= 0.
  - The first fall after reset is the MSB.
- EN=0: bit_cnt and sreg are held at 0 and no push occurs, which discards any partial word.
  - Word alignment requires EN to rise before the first COMP_CLK rise following SAR XRST release. This is a system-level rule.
- FIFO (first-word fall-through):
  - DOUT_DATA = mem[rd_ptr]; DOUT_VALID = (level!=0); pop = DOUT_VALID & DOUT_READY.
  - Push then pop latency: a word is visible on DOUT_VALID/DOUT_DATA the cycle after its push cycle.
  - Not full, push: write mem[wr_ptr], wr_ptr++ (wraps modulo DEPTH), level++, WORD_CNT++.
  - Full, push, no pop: word dropped; OVERFLOW<=1; level, pointers and WORD_CNT unchanged.
  - Full, push and pop in the same cycle: both succeed, level stays DEPTH, no overflow.
  - Pop only: rd_ptr++, level--.
  - Push+pop when not full: both succeed, level unchanged.
  - DOUT_READY while empty has no effect.
- OVERFLOW: cleared by CLR_OVF=1 unless a drop occurs the same cycle; set wins.
- DOUT_DATA/DOUT_VALID hold while DOUT_VALID=1 and DOUT_READY=0 (AXI-style stability).
- Reset mid-word or mid-FIFO: all state returns to reset values immediately; buffered words are lost.
- Throughput: one word per 48 CLK (8 bits x 6 CLK). The consumer needs one pop per 48 CLK on average to avoid overflow.

Test Plan:
- Basic assembly.
  - Stimulus: reset, EN=1, DOUT_READY=0; drive COMP_CLK pulses with DIGITAL_OUT bits 1,0,1,1,0,0,1,0 in SAR timing.
  - Required response: one cycle after the 8th fall, DOUT_VALID=1, DOUT_DATA=0xB2, FIFO_LEVEL=1, WORD_CNT=1.
- Fill and overflow.
  - Stimulus: DOUT_READY=0; send words 0x01,0x02,0x03,0x04,0x05.
  - Required response: FIFO_LEVEL=4; OVERFLOW=1 after the 5th word; WORD_CNT=4. Raising DOUT_READY then pops 0x01..0x04 in order, and 0x05 never appears.
- Full push+pop.
  - Stimulus: FIFO full with 0x10..0x13; assert DOUT_READY exactly in the cycle the 5th word 0x14 is pushed.
  - Required response: OVERFLOW stays 0, FIFO_LEVEL stays 4, subsequent pops give 0x11,0x12,0x13,0x14.
- Enable gating.
  - Stimulus: send 3 bits, drop EN for 2 COMP_CLK periods, raise EN, then send 8 bits forming 0xA5.
  - Required response: exactly one word 0xA5, WORD_CNT=1.
- CLR_OVF priority.
  - Stimulus: with OVERFLOW=1 and the FIFO full, assert CLR_OVF in the same cycle as a dropped push.
  - Required response: OVERFLOW remains 1. CLR_OVF in a later cycle clears it to 0.
- Reset mid-operation.
  - Stimulus: with FIFO_LEVEL=2 and bit_cnt=5, pulse RST asynchronously between CLK edges.
  - Required response: DOUT_VALID, FIFO_LEVEL, WORD_CNT and OVERFLOW are 0 immediately. The next 8 bits 0xFF produce DOUT_DATA=0xFF.
